// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART loopback block.
//   CLK_FREQ / BAUD : default system clock (Hz) and line rate (bit/s)
//   BAUD_CNT        : clocks per bit slot
//   BIT_MID         : baud-counter value at which a slot is sampled
//   SLOT_NUM        : slots per 8N1 frame (start, 8 data, stop)
//   state_t         : IDLE/BUSY state shared by the RX and TX engines
// Optional feature macro used by the design: UART_FRAME_CHECK_EN.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ = 50_000_000;
    localparam int BAUD     = 9600;
    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam int BIT_MID  = BAUD_CNT / 2 - 1;
    localparam int SLOT_NUM = 10;
    localparam int BAUD_W   = 13;
    localparam int BIT_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Sample point inside a bit slot for a given number of clocks per bit.
    function automatic logic [BAUD_W-1:0] mid_of(input int clks);
        return BAUD_W'(clks / 2 - 1);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 serial transmitter with a registered, glitch-free line output.
// Ports:
//   sclk     in   system clock, rising edge
//   s_rst_n  in   asynchronous active-low reset
//   tx_start in   load tx_data and send a frame (ignored while tx_busy)
//   tx_data  in   byte to send, LSB first
//   tx_busy  out  frame in progress; drops during the final stop-bit clock
//   rs232_tx out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int BAUD_CNT = uart_pkg::BAUD_CNT
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       rs232_tx
);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT - 1);
    localparam logic [BIT_W-1:0]  SLOT_LAST = BIT_W'(SLOT_NUM - 1);

    state_t            state_r, state_s;
    logic [BAUD_W-1:0] baud_cnt_r, baud_cnt_s;
    logic [BIT_W-1:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]        shift_r, shift_s;
    logic              tx_r, tx_s;
    logic              bit_end_s;
    logic              last_clk_s;

    assign bit_end_s  = (baud_cnt_r == BAUD_LAST);
    assign last_clk_s = (state_r == BUSY) && bit_end_s && (bit_cnt_r == SLOT_LAST);
    // Ready one clock early: a new frame loaded in the last stop clock starts
    // right after a full stop slot, so back-to-back echoes chain seamlessly.
    assign tx_busy    = (state_r == BUSY) && !last_clk_s;
    assign rs232_tx   = tx_r;

    // Next-state and next-output logic of the transmitter.
    always_comb begin
        state_s    = state_r;
        baud_cnt_s = baud_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        tx_s       = tx_r;
        if (tx_start && !tx_busy) begin
            state_s    = BUSY;
            baud_cnt_s = 13'd0;
            bit_cnt_s  = 4'd0;
            shift_s    = tx_data;
            tx_s       = 1'b0;
        end else if (state_r == BUSY) begin
            if (bit_end_s) begin
                baud_cnt_s = 13'd0;
                if (bit_cnt_r == SLOT_LAST) begin
                    state_s   = IDLE;
                    bit_cnt_s = 4'd0;
                    shift_s   = 8'd0;
                    tx_s      = 1'b1;
                end else if (bit_cnt_r <= 4'd7) begin
                    // Next slot is a data bit: shift out LSB first.
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    tx_s      = shift_r[0];
                    shift_s   = {1'b0, shift_r[7:1]};
                end else begin
                    // Next slot is the stop bit.
                    bit_cnt_s = bit_cnt_r + 4'd1;
                    tx_s      = 1'b1;
                end
            end else begin
                baud_cnt_s = baud_cnt_r + 13'd1;
            end
        end else begin
            tx_s = 1'b1;
        end
    end

    // Transmitter state and line register.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_r    <= IDLE;
            baud_cnt_r <= 13'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            state_r    <= state_s;
            baud_cnt_r <= baud_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            tx_r       <= tx_s;
        end
    end

endmodule

// File: rtl/uart_loopback_top.sv
// -----------------------------------------------------------------------------
// uart_loopback_top
// Board-level UART echo: every 8N1 byte received on rs232_rx is retransmitted
// unchanged on rs232_tx. Bytes arriving while the transmitter is busy are
// dropped.
// Ports:
//   sclk     in   system clock, rising edge
//   s_rst_n  in   asynchronous active-low reset
//   rs232_rx in   serial input, idle high, asynchronous to sclk
//   rs232_tx out  serial output, idle high
// Configuration macro: UART_FRAME_CHECK_EN
//   defined   - a stop bit sampled as 0 is a framing error: the byte is not
//               echoed and RX waits until the line samples high again.
//   undefined - the stop-bit value is ignored.
// -----------------------------------------------------------------------------
module uart_loopback_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = uart_pkg::CLK_FREQ,
    parameter int BAUD     = uart_pkg::BAUD
) (
    input  logic sclk,
    input  logic s_rst_n,
    input  logic rs232_rx,
    output logic rs232_tx
);

    localparam int BAUD_CNT = CLK_FREQ / BAUD;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_CNT - 1);
    localparam logic [BAUD_W-1:0] MID_CNT   = mid_of(BAUD_CNT);

    logic              rx_s1_r, rx_s2_r, rx_s3_r;
    logic              fall_s;
    state_t            rx_state_r, rx_state_s;
    logic [BAUD_W-1:0] rx_baud_cnt_r, rx_baud_cnt_s;
    logic [BIT_W-1:0]  rx_bit_cnt_r, rx_bit_cnt_s;
    logic [7:0]        rx_shift_r, rx_shift_s;
    logic [7:0]        rx_data_r, rx_data_s;
    logic              rx_done_r, rx_done_s;
    logic              tx_busy_s;
    logic              tx_start_s;

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rx_s1_r <= 1'b0;
            rx_s2_r <= 1'b0;
            rx_s3_r <= 1'b0;
        end else begin
            rx_s1_r <= rs232_rx;
            rx_s2_r <= rx_s1_r;
            rx_s3_r <= rx_s2_r;
        end
    end

    assign fall_s = rx_s3_r & ~rx_s2_r;

    // Receiver next-state logic. Slot 10 is only reachable with stop-bit
    // checking: it is the wait-for-line-high state after a framing error.
    always_comb begin
        rx_state_s    = rx_state_r;
        rx_baud_cnt_s = rx_baud_cnt_r;
        rx_bit_cnt_s  = rx_bit_cnt_r;
        rx_shift_s    = rx_shift_r;
        rx_data_s     = rx_data_r;
        rx_done_s     = 1'b0;
        case (rx_state_r)
            IDLE: begin
                if (fall_s) begin
                    rx_state_s    = BUSY;
                    rx_baud_cnt_s = 13'd0;
                    rx_bit_cnt_s  = 4'd0;
                    rx_shift_s    = 8'd0;
                end else begin
                    rx_state_s = IDLE;
                end
            end
            BUSY: begin
                if (rx_baud_cnt_r == BAUD_LAST) begin
                    rx_baud_cnt_s = 13'd0;
                    if (rx_bit_cnt_r < 4'd9) begin
                        rx_bit_cnt_s = rx_bit_cnt_r + 4'd1;
                    end else begin
                        rx_bit_cnt_s = rx_bit_cnt_r;
                    end
                end else begin
                    rx_baud_cnt_s = rx_baud_cnt_r + 13'd1;
                end
                if (rx_baud_cnt_r == MID_CNT) begin
                    if (rx_bit_cnt_r == 4'd0) begin
                        // A start bit that is high again at mid-slot is a glitch.
                        if (rx_s2_r) begin
                            rx_state_s    = IDLE;
                            rx_baud_cnt_s = 13'd0;
                            rx_bit_cnt_s  = 4'd0;
                        end else begin
                            rx_state_s = BUSY;
                        end
                    end else if (rx_bit_cnt_r <= 4'd8) begin
                        rx_shift_s = {rx_s2_r, rx_shift_r[7:1]};
                    end else if (rx_bit_cnt_r == 4'd9) begin
`ifdef UART_FRAME_CHECK_EN
                        if (rx_s2_r) begin
                            rx_done_s     = 1'b1;
                            rx_data_s     = rx_shift_r;
                            rx_state_s    = IDLE;
                            rx_baud_cnt_s = 13'd0;
                            rx_bit_cnt_s  = 4'd0;
                        end else begin
                            rx_bit_cnt_s = 4'd10;
                        end
`else
                        rx_done_s     = 1'b1;
                        rx_data_s     = rx_shift_r;
                        rx_state_s    = IDLE;
                        rx_baud_cnt_s = 13'd0;
                        rx_bit_cnt_s  = 4'd0;
`endif
                    end else begin
                        if (rx_s2_r) begin
                            rx_state_s    = IDLE;
                            rx_baud_cnt_s = 13'd0;
                            rx_bit_cnt_s  = 4'd0;
                        end else begin
                            rx_state_s = BUSY;
                        end
                    end
                end else begin
                    rx_shift_s = rx_shift_r;
                end
            end
            default: begin
                rx_state_s    = IDLE;
                rx_baud_cnt_s = 13'd0;
                rx_bit_cnt_s  = 4'd0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            rx_state_r    <= IDLE;
            rx_baud_cnt_r <= 13'd0;
            rx_bit_cnt_r  <= 4'd0;
            rx_shift_r    <= 8'd0;
            rx_data_r     <= 8'd0;
            rx_done_r     <= 1'b0;
        end else begin
            rx_state_r    <= rx_state_s;
            rx_baud_cnt_r <= rx_baud_cnt_s;
            rx_bit_cnt_r  <= rx_bit_cnt_s;
            rx_shift_r    <= rx_shift_s;
            rx_data_r     <= rx_data_s;
            rx_done_r     <= rx_done_s;
        end
    end

    assign tx_start_s = rx_done_r & ~tx_busy_s;

    uart_tx #(
        .BAUD_CNT (BAUD_CNT)
    ) u_tx (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .tx_start (tx_start_s),
        .tx_data  (rx_data_r),
        .tx_busy  (tx_busy_s),
        .rs232_tx (rs232_tx)
    );

endmodule

// File: tb/tb_uart_loopback_top.sv
// -----------------------------------------------------------------------------
// tb_uart_loopback_top
// Drives 8N1 frames into uart_loopback_top at a scaled-down baud rate and
// decodes the echoed line independently. Expected bytes come from a queue
// model of the echo rules; UART_FRAME_CHECK_EN selects the stop-bit rule.
// -----------------------------------------------------------------------------
module tb_uart_loopback_top;

    localparam int TB_CLK  = 1_600_000;
    localparam int TB_BAUD = 100_000;
    localparam int BIT     = TB_CLK / TB_BAUD;
`ifdef UART_FRAME_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic sclk = 1'b0;
    logic s_rst_n = 1'b0;
    logic rs232_rx = 1'b1;
    logic rs232_tx;

    int n_pass = 0;
    int n_total = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] rxd_q[$];

    uart_loopback_top #(
        .CLK_FREQ (TB_CLK),
        .BAUD     (TB_BAUD)
    ) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .rs232_rx (rs232_rx),
        .rs232_tx (rs232_tx)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive slots 0..nslots-1 of an 8N1 frame, one bit period each.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int nslots);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int k = 0; k < nslots; k++) begin
            rs232_rx = fr[k];
            repeat (BIT) @(negedge sclk);
        end
    endtask

    task automatic idle_bits(input int n);
        rs232_rx = 1'b1;
        repeat (n * BIT) @(negedge sclk);
    endtask

    // Reference rule: a frame is echoed unless stop checking rejects it.
    task automatic send_and_model(input logic [7:0] d, input logic stop);
        send_frame(d, stop, 10);
        if (stop || !FCHK) exp_q.push_back(d);
    endtask

    // Observe the byte handed to the transmitter.
    always @(negedge sclk) begin
        if (dut.rx_done_r) rxd_q.push_back(dut.rx_data_r);
    end

    // Independent line decoder: captures a whole frame clock by clock and
    // requires every slot to be exactly BIT clocks of a constant level.
    initial begin : tx_mon
        logic samp [10*BIT];
        logic [7:0] b;
        int bad;
        forever begin
            @(negedge sclk);
            if (s_rst_n && rs232_tx == 1'b0) begin
                samp[0] = rs232_tx;
                for (int c = 1; c < 10 * BIT; c++) begin
                    @(negedge sclk);
                    samp[c] = rs232_tx;
                end
                bad = 0;
                for (int k = 0; k < 10; k++) begin
                    for (int j = 0; j < BIT; j++) begin
                        if (samp[k*BIT+j] !== samp[k*BIT+BIT/2]) bad++;
                    end
                end
                for (int k = 0; k < 8; k++) b[k] = samp[(k+1)*BIT + BIT/2];
                check("tx_slot_width", bad, 0);
                check("tx_stop_bit", {31'd0, samp[9*BIT + BIT/2]}, 1);
                got_q.push_back(b);
            end
        end
    end

    initial begin : stim
        int seen_low;
        int n_got;
        int n_rxd;
        logic [7:0] d;
        logic stop;

        // Reset and idle line.
        repeat (8) @(negedge sclk);
        check("tx_in_reset", {31'd0, rs232_tx}, 1);
        s_rst_n = 1'b1;
        seen_low = 0;
        for (int i = 0; i < 20 * BIT; i++) begin
            @(negedge sclk);
            if (rs232_tx !== 1'b1) seen_low++;
        end
        check("tx_idle_after_reset", seen_low, 0);
        check("no_rx_done_idle", rxd_q.size(), 0);

        // 0x55 echo.
        send_and_model(8'h55, 1'b1);
        idle_bits(12);
        check("echo_55_count", got_q.size(), 1);
        check("echo_55_rxd_count", rxd_q.size(), 1);

        // Short low glitch is a false start.
        n_got = got_q.size();
        n_rxd = rxd_q.size();
        rs232_rx = 1'b0;
        repeat (3) @(negedge sclk);
        seen_low = 0;
        rs232_rx = 1'b1;
        for (int i = 0; i < 12 * BIT; i++) begin
            @(negedge sclk);
            if (rs232_tx !== 1'b1) seen_low++;
        end
        check("glitch_tx_idle", seen_low, 0);
        check("glitch_no_rx_done", rxd_q.size(), n_rxd);
        check("glitch_no_echo", got_q.size(), n_got);
        send_and_model(8'hA3, 1'b1);
        idle_bits(12);
        check("echo_a3_count", got_q.size(), n_got + 1);

        // Back-to-back frames.
        n_got = got_q.size();
        send_and_model(8'h00, 1'b1);
        send_and_model(8'hFF, 1'b1);
        idle_bits(12);
        check("b2b_count", got_q.size(), n_got + 2);

        // Reset in the middle of bit 4 aborts the frame.
        n_got = got_q.size();
        n_rxd = rxd_q.size();
        send_frame(8'h96, 1'b1, 4);
        rs232_rx = 1'b0;
        repeat (BIT / 2) @(negedge sclk);
        s_rst_n = 1'b0;
        rs232_rx = 1'b1;
        @(negedge sclk);
        check("tx_high_in_reset", {31'd0, rs232_tx}, 1);
        repeat (2) @(negedge sclk);
        s_rst_n = 1'b1;
        idle_bits(12);
        check("reset_no_echo", got_q.size(), n_got);
        check("reset_no_rx_done", rxd_q.size(), n_rxd);
        send_and_model(8'h3C, 1'b1);
        idle_bits(12);
        check("echo_3c_count", got_q.size(), n_got + 1);

        // Stop bit driven low.
        n_got = got_q.size();
        send_and_model(8'h5A, 1'b0);
        idle_bits(12);
        check("bad_stop_count", got_q.size(), n_got + (FCHK ? 0 : 1));

        // Randomized traffic with random gaps; a bad stop is followed by idle.
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 7) != 0);
            send_and_model(d, stop);
            if (!stop) idle_bits(2 + $urandom_range(0, 1));
            else idle_bits($urandom_range(0, 2));
        end
        idle_bits(14);

        // Final in-order comparison against the model.
        check("echo_total", got_q.size(), exp_q.size());
        check("rx_done_total", rxd_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("echo_byte_%0d", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
            if (i < rxd_q.size()) check($sformatf("rx_data_%0d", i), {24'd0, rxd_q[i]}, {24'd0, exp_q[i]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
